// File: rtl/aurora_flow_nfc.sv
// Aurora native flow control: XOFF on RX FIFO prog_full, XON after a quiet hold.
// Optional statistics counters are built when AURORA_NFC_STATS_EN is defined.
module aurora_flow_nfc #(
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned STAT_WIDTH  = 32
) (
  input  logic                  user_clk,
  input  logic                  rst_u,
  input  logic                  nfc_enable_u,
  input  logic                  fifo_rx_prog_full_u,
  input  logic                  fifo_rx_almost_full_u,
  input  logic                  m_axi_rx_tvalid_u,
  output logic                  s_axi_nfc_tvalid_u,
  input  logic                  s_axi_nfc_tready_u,
  output logic [15:0]           s_axi_nfc_tdata_u,
  output logic                  xoff_active_u,
  output logic [STAT_WIDTH-1:0] xoff_count_u,
  output logic [STAT_WIDTH-1:0] xoff_cycles_u,
  output logic [STAT_WIDTH-1:0] margin_viol_u
);

  localparam logic [2:0] INIT_XON  = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] SEND_XOFF = 3'd2;
  localparam logic [2:0] PAUSED    = 3'd3;
  localparam logic [2:0] SEND_XON  = 3'd4;

  localparam logic [15:0] XOFF_WORD = 16'h0100;
  localparam logic [15:0] XON_WORD  = 16'h0000;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [15:0] hold_cnt;
  logic [15:0] hold_nx;
  logic        accept;
  logic        send_nx;

  // tready only counts while a request is actually on the bus
  assign accept  = s_axi_nfc_tvalid_u & s_axi_nfc_tready_u;
  assign send_nx = (state_nx == INIT_XON) |
                   (state_nx == SEND_XOFF) |
                   (state_nx == SEND_XON);

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    unique case (state)
      INIT_XON: begin
        if (accept) state_nx = IDLE;
      end
      IDLE: begin
        hold_nx = '0;
        if (nfc_enable_u && fifo_rx_prog_full_u)
          state_nx = SEND_XOFF;
      end
      SEND_XOFF: begin
        hold_nx = '0;
        if (accept) state_nx = PAUSED;
      end
      PAUSED: begin
        if (!nfc_enable_u) begin
          state_nx = SEND_XON;
          hold_nx  = '0;
        end else if (fifo_rx_prog_full_u) begin
          hold_nx = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = SEND_XON;
          hold_nx  = '0;
        end else begin
          hold_nx = hold_cnt + 16'd1;
        end
      end
      SEND_XON: begin
        if (accept) state_nx = IDLE;
      end
      default: begin
        state_nx = INIT_XON;
        hold_nx  = '0;
      end
    endcase
  end

  // tvalid/tdata are registered from the next state, so they never glitch
  always_ff @(posedge user_clk) begin
    if (rst_u) begin
      state              <= INIT_XON;
      hold_cnt           <= '0;
      s_axi_nfc_tvalid_u <= 1'b0;
      s_axi_nfc_tdata_u  <= XON_WORD;
      xoff_active_u      <= 1'b0;
    end else begin
      state              <= state_nx;
      hold_cnt           <= hold_nx;
      s_axi_nfc_tvalid_u <= send_nx;
      s_axi_nfc_tdata_u  <= (state_nx == SEND_XOFF) ? XOFF_WORD : XON_WORD;
      if (accept && state == SEND_XOFF)
        xoff_active_u <= 1'b1;
      else if (accept && state == SEND_XON)
        xoff_active_u <= 1'b0;
    end
  end

`ifdef AURORA_NFC_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

  always_ff @(posedge user_clk) begin
    if (rst_u) begin
      xoff_count_u  <= '0;
      xoff_cycles_u <= '0;
      margin_viol_u <= '0;
    end else begin
      if (accept && state == SEND_XOFF && xoff_count_u != '1)
        xoff_count_u <= xoff_count_u + STAT_ONE;
      if (xoff_active_u && xoff_cycles_u != '1)
        xoff_cycles_u <= xoff_cycles_u + STAT_ONE;
      if (m_axi_rx_tvalid_u && fifo_rx_almost_full_u &&
          margin_viol_u != '1)
        margin_viol_u <= margin_viol_u + STAT_ONE;
    end
  end
`else
  logic unused_stat_inputs;

  assign unused_stat_inputs = m_axi_rx_tvalid_u & fifo_rx_almost_full_u;
  assign xoff_count_u  = '0;
  assign xoff_cycles_u = '0;
  assign margin_viol_u = '0;
`endif

endmodule

// File: tb/tb_aurora_flow_nfc.sv
// Directed bench for aurora_flow_nfc: a request/pause model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_aurora_flow_nfc;

  localparam int HOLD = 64;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;
  localparam logic [15:0] XOFF = 16'h0100;
  localparam logic [15:0] XON  = 16'h0000;
`ifdef AURORA_NFC_STATS_EN
  localparam int EXP_MARGIN = 15;
`else
  localparam int EXP_MARGIN = 0;
`endif

  logic          user_clk = 1'b0;
  logic          rst_u = 1'b1;
  logic          en = 1'b0;
  logic          pf = 1'b0;
  logic          af = 1'b0;
  logic          rxv = 1'b0;
  logic          tready = 1'b0;
  logic          tvalid;
  logic [15:0]   tdata;
  logic          active;
  logic [SW-1:0] xc;
  logic [SW-1:0] xcy;
  logic [SW-1:0] mvio;

  int checks = 0;
  int errors = 0;

  aurora_flow_nfc #(.HOLD_CYCLES(HOLD), .STAT_WIDTH(SW)) dut (
    .user_clk              (user_clk),
    .rst_u                 (rst_u),
    .nfc_enable_u          (en),
    .fifo_rx_prog_full_u   (pf),
    .fifo_rx_almost_full_u (af),
    .m_axi_rx_tvalid_u     (rxv),
    .s_axi_nfc_tvalid_u    (tvalid),
    .s_axi_nfc_tready_u    (tready),
    .s_axi_nfc_tdata_u     (tdata),
    .xoff_active_u         (active),
    .xoff_count_u          (xc),
    .xoff_cycles_u         (xcy),
    .margin_viol_u         (mvio)
  );

  always #5 user_clk = ~user_clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  // Model: what is on the NFC bus, whether the remote is held off,
  // how long the FIFO has been quiet, and the event tallies.
  bit          m_valid;
  logic [15:0] m_data;
  bit          m_active;
  bit          m_off;
  bit          m_init;
  int          m_run;
  int          m_cnt;
  int          m_cyc;
  int          m_mar;
  bit          m_live = 1'b0;
  bit          m_acc;

  function automatic int sat(input int v);
    return (v < SMAX) ? v + 1 : SMAX;
  endfunction

  always @(posedge user_clk) begin
    if (rst_u) begin
      m_valid = 1'b0; m_data = XON; m_active = 1'b0; m_off = 1'b0;
      m_init = 1'b1; m_run = 0;
      m_cnt = 0; m_cyc = 0; m_mar = 0; m_live = 1'b1;
    end else begin
      m_acc = m_valid && tready;
      if (rxv && af) m_mar = sat(m_mar);
      if (m_active) m_cyc = sat(m_cyc);
      if (m_acc && m_data == XOFF) m_cnt = sat(m_cnt);
      if (m_acc) begin
        m_valid = 1'b0;
        m_off = (m_data == XOFF);
        m_active = m_off;
        if (m_data == XON) m_init = 1'b0;
        m_run = 0;
      end else if (!m_valid) begin
        if (m_init) begin
          m_valid = 1'b1; m_data = XON;
        end else if (!m_off) begin
          if (en && pf) begin m_valid = 1'b1; m_data = XOFF; end
        end else if (!en) begin
          m_valid = 1'b1; m_data = XON;
        end else if (pf) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == HOLD) begin
            m_valid = 1'b1; m_data = XON; m_run = 0;
          end
        end
      end
    end
  end

  always @(negedge user_clk) begin
    if (m_live) begin
      chk("tvalid", tvalid, m_valid);
      if (m_valid) chk("tdata", tdata, m_data);
      chk("xoff_active", active, m_active);
`ifdef AURORA_NFC_STATS_EN
      chk("xoff_count", xc, m_cnt);
      chk("xoff_cycles", xcy, m_cyc);
      chk("margin_viol", mvio, m_mar);
`else
      chk("xoff_count", xc, 0);
      chk("xoff_cycles", xcy, 0);
      chk("margin_viol", mvio, 0);
`endif
    end
  end

  initial begin
    rst_u = 1'b1; tready = 1'b0; en = 1'b1;
    repeat (3) step();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_active", active, 0);
    rst_u = 1'b0; tready = 1'b1;
    step(); chk("init_xon_v", tvalid, 1); chk("init_xon_d", tdata, XON);
    step(); chk("init_done_v", tvalid, 0);
    repeat (8) step();

    pf = 1'b1;
    step(); chk("xoff_lat_v", tvalid, 1); chk("xoff_d", tdata, XOFF);
    step(); chk("xoff_acc_act", active, 1); chk("xoff_acc_v", tvalid, 0);
    repeat (39) step();
    pf = 1'b0;
    repeat (63) step();
    chk("hold63_v", tvalid, 0); chk("hold63_act", active, 1);
    step(); chk("xon_v", tvalid, 1); chk("xon_d", tdata, XON);
    step(); chk("xon_acc_act", active, 0); chk("xon_acc_v", tvalid, 0);

    tready = 1'b0; pf = 1'b1;
    step(); chk("stall_first_v", tvalid, 1);
    pf = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(); chk("stall_v", tvalid, 1); chk("stall_d", tdata, XOFF);
    end
    tready = 1'b1;
    step(); chk("stall_acc_v", tvalid, 0); chk("stall_acc_act", active, 1);

    repeat (63) step(); chk("run63_v", tvalid, 0);
    pf = 1'b1; step(); pf = 1'b0;
    repeat (63) step(); chk("rerun63_v", tvalid, 0);
    step(); chk("rerun64_v", tvalid, 1); chk("rerun64_d", tdata, XON);
    step();

    pf = 1'b1; step(); step();
    pf = 1'b0; en = 1'b0;
    step(); chk("dis_xon_v", tvalid, 1); chk("dis_xon_d", tdata, XON);
    step(); chk("dis_acc_v", tvalid, 0); chk("dis_acc_act", active, 0);
    en = 1'b1;

    pf = 1'b1; step(); step();
    pf = 1'b0;
    repeat (64) step(); chk("pre_reassert_v", tvalid, 1);
    tready = 1'b0; pf = 1'b1;
    repeat (3) begin
      step(); chk("xon_hold_v", tvalid, 1); chk("xon_hold_d", tdata, XON);
    end
    tready = 1'b1;
    step(); chk("reassert_acc_v", tvalid, 0); chk("reassert_act", active, 0);
    step(); chk("reassert_xoff_v", tvalid, 1); chk("reassert_d", tdata, XOFF);
    pf = 1'b0; step();
    repeat (64) step(); chk("tail_xon_v", tvalid, 1);
    step();

    tready = 1'b0; pf = 1'b1;
    step(); chk("rst_mid_v", tvalid, 1); chk("rst_mid_d", tdata, XOFF);
    rst_u = 1'b1;
    step(); chk("rst_drop_v", tvalid, 0); chk("rst_drop_act", active, 0);
    step();
    rst_u = 1'b0; pf = 1'b0;
    step(); chk("rst_init_v", tvalid, 1); chk("rst_init_d", tdata, XON);
    tready = 1'b1;
    step(); chk("rst_init_acc_v", tvalid, 0);
    chk("cnt_after_rst", xc, 0);

    af = 1'b1; rxv = 1'b1;
    repeat (20) step();
    af = 1'b0; rxv = 1'b0;
    step(); chk("margin_sat", mvio, EXP_MARGIN);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
